// File: rtl/aes_ct_unpacker.sv
// AES ciphertext unpacker: block FIFO + 128->32 serialiser on valid/ready.
// Optional AES_UNPACK_STATS_EN adds blk_cnt / drop_cnt counters.
module aes_ct_unpacker #(
  parameter int DEPTH     = 4,
  parameter bit MSW_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [127:0]           ct_in,
  input  logic                   ct_valid,
  output logic [31:0]            m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clr_ovf
`ifdef AES_UNPACK_STATS_EN
  ,
  output logic [15:0]            blk_cnt,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic {EMPTY, SEND} state_t;

  state_t          state_q, state_d;
  logic [127:0]    mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [1:0]      widx_q, widx_d;
  logic            ovf_q, ovf_d;
  logic            xfer, pop, push, drop;
  logic [127:0]    head;
  logic [1:0]      sel;

  always_comb begin
    xfer     = (state_q == SEND) && m_ready;
    pop      = xfer && (widx_q == 2'd3);
    push     = ct_valid && (!full || pop);
    drop     = ct_valid && !push;
    widx_d   = xfer ? widx_q + 2'd1 : widx_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    level_d  = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    state_d  = (level_d != '0) ? SEND : EMPTY;
    ovf_d    = drop | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      widx_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      widx_q   <= widx_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: m_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= ct_in;
  end

  always_comb begin
    head     = mem[rd_ptr_q];
    sel      = MSW_FIRST ? ~widx_q : widx_q;
    m_valid  = (state_q == SEND);
    m_data   = m_valid ? head[{sel, 5'd0} +: 32] : 32'd0;
    m_last   = m_valid && (widx_q == 2'd3);
    full     = (level_q == LW'(DEPTH));
    level    = level_q;
    overflow = ovf_q;
  end

`ifdef AES_UNPACK_STATS_EN
  logic [15:0] blk_q, blk_d;
  logic [15:0] drp_q, drp_d;

  // An increment coinciding with a clear restarts the count at 1.
  always_comb begin
    blk_d = blk_q;
    if (pop)
      blk_d = clr_ovf ? 16'd1 :
              (blk_q == 16'hFFFF) ? blk_q : blk_q + 16'd1;
    else if (clr_ovf)
      blk_d = '0;
    drp_d = drp_q;
    if (drop)
      drp_d = clr_ovf ? 16'd1 :
              (drp_q == 16'hFFFF) ? drp_q : drp_q + 16'd1;
    else if (clr_ovf)
      drp_d = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blk_q <= '0;
      drp_q <= '0;
    end else begin
      blk_q <= blk_d;
      drp_q <= drp_d;
    end
  end

  assign blk_cnt  = blk_q;
  assign drop_cnt = drp_q;
`endif

endmodule
